// File: rtl/mem_issue_queue_pkg.sv
// Shared definitions for the memory issue queue: physical register tag width,
// opcode/flag bit positions, ROB index width and small decode helpers.
`ifndef PR_ADDR_W
`define PR_ADDR_W 6
`endif

package mem_issue_queue_pkg;
  localparam int PR_W           = `PR_ADDR_W;
  localparam int OPC_STORE_BIT  = 0;
  localparam int IMM_ZPWRAP_BIT = 3;
  localparam int ROB_IDX_W      = 5;

  function automatic logic is_store(input logic [3:0] opcode);
    return opcode[OPC_STORE_BIT];
  endfunction

  // A not-ready operand whose tag is on the CDB this cycle.
  function automatic logic cdb_hit(input logic cdb_valid, input logic [PR_W-1:0] cdb_tag,
                                   input logic rdy, input logic [PR_W-1:0] tag);
    return cdb_valid && !rdy && (tag == cdb_tag);
  endfunction
endpackage

// File: rtl/mem_iq_operand.sv
// One operand slot of an issue-queue entry: ready bit, producer tag and value.
// Loaded at dispatch, woken by a matching CDB broadcast, cleared on flush.
`ifndef PR_ADDR_W
`define PR_ADDR_W 6
`endif

module mem_iq_operand
  import mem_issue_queue_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            wr,
  input  logic            wr_rdy,
  input  logic [PR_W-1:0] wr_tag,
  input  logic [7:0]      wr_val,
  input  logic            cdb_valid,
  input  logic [PR_W-1:0] cdb_tag,
  input  logic [7:0]      cdb_data,
  output logic            rdy,
  output logic [PR_W-1:0] tag,
  output logic [7:0]      val
);

  logic wake;
  assign wake = cdb_hit(cdb_valid, cdb_tag, rdy, tag);

  // Dispatch write takes precedence; otherwise capture a matching broadcast.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rdy <= 1'b0;
    end else if (wr) begin
      rdy <= wr_rdy;
      tag <= wr_tag;
      val <= wr_val;
    end else if (wake) begin
      rdy <= 1'b1;
      val <= cdb_data;
    end
  end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue between dispatch and the memory pipeline.
// Ops wait for their operands on the CDB and issue strictly in program order;
// stores additionally wait until they are the ROB head.
// Build option MEM_IQ_CDB_BYPASS_EN: operands whose tag is on the CDB in the
// dispatch cycle are written ready with the CDB value. Without it, such a
// dispatch is refused for that cycle and retried.
`ifndef PR_ADDR_W
`define PR_ADDR_W 6
`endif

module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [3:0]           disp_opcode,
  input  logic [ROB_IDX_W-1:0] disp_rob,
  input  logic [3:0]           disp_imm,
  input  logic [7:0]           disp_base_hi,
  input  logic                 disp_blo_rdy,
  input  logic [PR_W-1:0]      disp_blo_tag,
  input  logic [7:0]           disp_blo_val,
  input  logic                 disp_off_rdy,
  input  logic [PR_W-1:0]      disp_off_tag,
  input  logic [7:0]           disp_off_val,
  input  logic                 disp_dat_rdy,
  input  logic [PR_W-1:0]      disp_dat_tag,
  input  logic [7:0]           disp_dat_val,
  input  logic [PR_W-1:0]      disp_dest_reg,
  input  logic [3:0]           disp_dest_arch,
  input  logic                 cdb_valid,
  input  logic [PR_W-1:0]      cdb_tag,
  input  logic [7:0]           cdb_data,
  input  logic [ROB_IDX_W-1:0] rob_head,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [3:0]           iss_opcode,
  output logic [ROB_IDX_W-1:0] iss_rob,
  output logic [3:0]           iss_imm,
  output logic [3:0]           iss_dest_arch,
  output logic [15:0]          iss_base,
  output logic [7:0]           iss_offset,
  output logic [7:0]           iss_data,
  output logic [PR_W-1:0]      iss_dest_reg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  logic [PTR_W:0]   head, tail;
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] hidx, tidx;
  logic             full, do_disp, do_iss;

  logic [3:0]           opc_q       [DEPTH];
  logic [ROB_IDX_W-1:0] rob_q       [DEPTH];
  logic [3:0]           imm_q       [DEPTH];
  logic [7:0]           base_hi_q   [DEPTH];
  logic [PR_W-1:0]      dest_reg_q  [DEPTH];
  logic [3:0]           dest_arch_q [DEPTH];

  logic            blo_rdy [DEPTH], off_rdy [DEPTH], dat_rdy [DEPTH];
  logic [PR_W-1:0] blo_tag [DEPTH], off_tag [DEPTH], dat_tag [DEPTH];
  logic [7:0]      blo_val [DEPTH], off_val [DEPTH], dat_val [DEPTH];

  assign hidx = head[PTR_W-1:0];
  assign tidx = tail[PTR_W-1:0];
  assign full = (head[PTR_W] != tail[PTR_W]) && (hidx == tidx);

  // Loads have no data operand, so it is ready from the start.
  logic dat_rdy_in;
  logic blo_hit, off_hit, dat_hit;
  assign dat_rdy_in = disp_dat_rdy || !is_store(disp_opcode);
  assign blo_hit    = cdb_hit(cdb_valid, cdb_tag, disp_blo_rdy, disp_blo_tag);
  assign off_hit    = cdb_hit(cdb_valid, cdb_tag, disp_off_rdy, disp_off_tag);
  assign dat_hit    = cdb_hit(cdb_valid, cdb_tag, dat_rdy_in,   disp_dat_tag);

  logic       blo_rdy_w, off_rdy_w, dat_rdy_w;
  logic [7:0] blo_val_w, off_val_w, dat_val_w;

`ifdef MEM_IQ_CDB_BYPASS_EN
  assign blo_rdy_w  = disp_blo_rdy || blo_hit;
  assign off_rdy_w  = disp_off_rdy || off_hit;
  assign dat_rdy_w  = dat_rdy_in   || dat_hit;
  assign blo_val_w  = blo_hit ? cdb_data : disp_blo_val;
  assign off_val_w  = off_hit ? cdb_data : disp_off_val;
  assign dat_val_w  = dat_hit ? cdb_data : disp_dat_val;
  assign disp_ready = !full;
`else
  // The broadcast would be missed by an entry not yet written; refuse and retry.
  assign blo_rdy_w  = disp_blo_rdy;
  assign off_rdy_w  = disp_off_rdy;
  assign dat_rdy_w  = dat_rdy_in;
  assign blo_val_w  = disp_blo_val;
  assign off_val_w  = disp_off_val;
  assign dat_val_w  = disp_dat_val;
  assign disp_ready = !full && !(blo_hit || off_hit || dat_hit);
`endif

  assign do_disp = disp_valid && disp_ready && !flush;

  // Head issues once every operand is ready; stores also need to be the ROB head.
  assign iss_valid = valid[hidx] && blo_rdy[hidx] && off_rdy[hidx] && dat_rdy[hidx] &&
                     (!is_store(opc_q[hidx]) || (rob_head == rob_q[hidx]));
  assign do_iss    = iss_valid && iss_ready && !flush;

  assign iss_opcode    = opc_q[hidx];
  assign iss_rob       = rob_q[hidx];
  assign iss_imm       = imm_q[hidx];
  assign iss_dest_arch = dest_arch_q[hidx];
  assign iss_base      = {base_hi_q[hidx], blo_val[hidx]};
  assign iss_offset    = off_val[hidx];
  assign iss_data      = dat_val[hidx];
  assign iss_dest_reg  = dest_reg_q[hidx];

  // Pointer and valid-bit bookkeeping; flush empties the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
    end else begin
      if (do_disp) begin
        valid[tidx] <= 1'b1;
        tail        <= tail + PTR_ONE;
      end
      if (do_iss) begin
        valid[hidx] <= 1'b0;
        head        <= head + PTR_ONE;
      end
    end
  end

  // Static entry fields written at dispatch.
  always_ff @(posedge clk) begin
    if (do_disp) begin
      opc_q[tidx]       <= disp_opcode;
      rob_q[tidx]       <= disp_rob;
      imm_q[tidx]       <= disp_imm;
      base_hi_q[tidx]   <= disp_base_hi;
      dest_reg_q[tidx]  <= disp_dest_reg;
      dest_arch_q[tidx] <= disp_dest_arch;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic wr_slot;
    assign wr_slot = do_disp && (tidx == PTR_W'(i));

    mem_iq_operand u_blo (
      .clk(clk), .rst(rst), .clr(flush), .wr(wr_slot),
      .wr_rdy(blo_rdy_w), .wr_tag(disp_blo_tag), .wr_val(blo_val_w),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rdy(blo_rdy[i]), .tag(blo_tag[i]), .val(blo_val[i])
    );
    mem_iq_operand u_off (
      .clk(clk), .rst(rst), .clr(flush), .wr(wr_slot),
      .wr_rdy(off_rdy_w), .wr_tag(disp_off_tag), .wr_val(off_val_w),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rdy(off_rdy[i]), .tag(off_tag[i]), .val(off_val[i])
    );
    mem_iq_operand u_dat (
      .clk(clk), .rst(rst), .clr(flush), .wr(wr_slot),
      .wr_rdy(dat_rdy_w), .wr_tag(disp_dat_tag), .wr_val(dat_val_w),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rdy(dat_rdy[i]), .tag(dat_tag[i]), .val(dat_val[i])
    );
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Self-checking bench for mem_issue_queue: table-driven dispatch/issue with a
// scoreboard, plus hand-written sequences for wakeup, store ordering, full,
// flush and same-cycle CDB dispatch.
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;

  typedef struct packed {
    logic [3:0]      opcode;
    logic [4:0]      rob;
    logic [3:0]      imm;
    logic [7:0]      base_hi;
    logic            blo_rdy;
    logic [PR_W-1:0] blo_tag;
    logic [7:0]      blo_val;
    logic            off_rdy;
    logic [PR_W-1:0] off_tag;
    logic [7:0]      off_val;
    logic            dat_rdy;
    logic [PR_W-1:0] dat_tag;
    logic [7:0]      dat_val;
    logic [PR_W-1:0] dest_reg;
    logic [3:0]      dest_arch;
  } op_t;

  typedef struct packed {
    logic [3:0]      opcode;
    logic [4:0]      rob;
    logic [15:0]     base;
    logic [7:0]      off;
    logic [7:0]      dat;
    logic [PR_W-1:0] dest_reg;
  } exp_t;

  typedef struct packed {
    op_t  op;
    exp_t exp;
  } vec_t;

  logic clk = 1'b0, rst, flush, disp_valid, disp_ready;
  logic [3:0] disp_opcode, disp_imm, disp_dest_arch;
  logic [4:0] disp_rob, rob_head;
  logic [7:0] disp_base_hi, disp_blo_val, disp_off_val, disp_dat_val, cdb_data;
  logic disp_blo_rdy, disp_off_rdy, disp_dat_rdy, cdb_valid;
  logic [PR_W-1:0] disp_blo_tag, disp_off_tag, disp_dat_tag, disp_dest_reg, cdb_tag;
  logic iss_valid, iss_ready;
  logic [3:0] iss_opcode, iss_imm, iss_dest_arch;
  logic [4:0] iss_rob;
  logic [15:0] iss_base;
  logic [7:0] iss_offset, iss_data;
  logic [PR_W-1:0] iss_dest_reg;

  mem_issue_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_rob(disp_rob), .disp_imm(disp_imm),
    .disp_base_hi(disp_base_hi),
    .disp_blo_rdy(disp_blo_rdy), .disp_blo_tag(disp_blo_tag), .disp_blo_val(disp_blo_val),
    .disp_off_rdy(disp_off_rdy), .disp_off_tag(disp_off_tag), .disp_off_val(disp_off_val),
    .disp_dat_rdy(disp_dat_rdy), .disp_dat_tag(disp_dat_tag), .disp_dat_val(disp_dat_val),
    .disp_dest_reg(disp_dest_reg), .disp_dest_arch(disp_dest_arch),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rob_head(rob_head),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_opcode(iss_opcode), .iss_rob(iss_rob), .iss_imm(iss_imm),
    .iss_dest_arch(iss_dest_arch), .iss_base(iss_base),
    .iss_offset(iss_offset), .iss_data(iss_data), .iss_dest_reg(iss_dest_reg)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  bit   sb_en = 1'b0;
  exp_t cur_exp;
  exp_t sb[$];
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic op_t mk_op(input logic [3:0] opc, input logic [4:0] rob,
                                input logic [7:0] bhi, input logic [7:0] blo,
                                input logic [7:0] off, input logic [7:0] dat,
                                input logic [PR_W-1:0] dest);
    op_t o;
    o = '0;
    o.opcode = opc; o.rob = rob; o.base_hi = bhi;
    o.blo_rdy = 1'b1; o.blo_val = blo;
    o.off_rdy = 1'b1; o.off_val = off;
    o.dat_rdy = 1'b1; o.dat_val = dat;
    o.dest_reg = dest;
    return o;
  endfunction

  task automatic idle();
    disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic drive(input op_t o, input exp_t e);
    disp_valid = 1'b1;
    disp_opcode = o.opcode; disp_rob = o.rob; disp_imm = o.imm; disp_base_hi = o.base_hi;
    disp_blo_rdy = o.blo_rdy; disp_blo_tag = o.blo_tag; disp_blo_val = o.blo_val;
    disp_off_rdy = o.off_rdy; disp_off_tag = o.off_tag; disp_off_val = o.off_val;
    disp_dat_rdy = o.dat_rdy; disp_dat_tag = o.dat_tag; disp_dat_val = o.dat_val;
    disp_dest_reg = o.dest_reg; disp_dest_arch = o.dest_arch;
    cur_exp = e;
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL sb_unexpected_issue: issued rob %0d with nothing expected", iss_rob);
      return;
    end
    e = sb.pop_front();
    check("sb_opcode", 32'(iss_opcode), 32'(e.opcode));
    check("sb_rob", 32'(iss_rob), 32'(e.rob));
    check("sb_base", 32'(iss_base), 32'(e.base));
    check("sb_offset", 32'(iss_offset), 32'(e.off));
    if (e.opcode[0]) check("sb_data", 32'(iss_data), 32'(e.dat));
    else check("sb_dest_reg", 32'(iss_dest_reg), 32'(e.dest_reg));
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs sampled 1 unit later.
  task automatic run_cycle();
    #1;
    if (sb_en && iss_valid && iss_ready) sb_check();
    if (sb_en && disp_valid && disp_ready && !flush) sb.push_back(cur_exp);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    iss_ready = 1'b1;
    for (int k = 0; k < 40 && sb.size() != 0; k++) run_cycle();
    check(name, 32'(sb.size()), 32'd0);
    #1 check({name, "_idle"}, 32'(iss_valid), 32'd0);
  endtask

  initial begin
    op_t o;
    exp_t e;
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    op_t o;
    exp_t e;
    tbl[0] = '{mk_op(4'h0, 5'd1, 8'h12, 8'h34, 8'h05, 8'h00, 6'd3),
               '{4'h0, 5'd1, 16'h1234, 8'h05, 8'h00, 6'd3}};
    tbl[1] = '{mk_op(4'h1, 5'd10, 8'hA0, 8'h00, 8'hFF, 8'h77, 6'd0),
               '{4'h1, 5'd10, 16'hA000, 8'hFF, 8'h77, 6'd0}};
    tbl[2] = '{mk_op(4'h0, 5'd2, 8'h00, 8'hFF, 8'h01, 8'h00, 6'd7),
               '{4'h0, 5'd2, 16'h00FF, 8'h01, 8'h00, 6'd7}};
    tbl[2].op.dat_rdy = 1'b0;   // a load's data operand is ignored
    tbl[2].op.dat_tag = 6'd3;
    tbl[3] = '{mk_op(4'h0, 5'd3, 8'hFF, 8'hFF, 8'h00, 8'h00, 6'd12),
               '{4'h0, 5'd3, 16'hFFFF, 8'h00, 8'h00, 6'd12}};
    tbl[4] = '{mk_op(4'h2, 5'd4, 8'h80, 8'h01, 8'h80, 8'h00, 6'd31),
               '{4'h2, 5'd4, 16'h8001, 8'h80, 8'h00, 6'd31}};
    tbl[5] = '{mk_op(4'h0, 5'd5, 8'h55, 8'h55, 8'hAA, 8'h00, 6'd40),
               '{4'h0, 5'd5, 16'h5555, 8'hAA, 8'h00, 6'd40}};

    idle(); iss_ready = 1'b0; rob_head = 5'd0;
    drive(mk_op(4'h0, 5'd0, 8'h00, 8'h00, 8'h00, 8'h00, 6'd0), '0);
    disp_valid = 1'b0;
    cdb_tag = '0; cdb_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_iss_valid", 32'(iss_valid), 32'd0);
    check("reset_disp_ready", 32'(disp_ready), 32'd1);

    // Load with all operands ready issues the next cycle.
    o = mk_op(4'h0, 5'd6, 8'h12, 8'h34, 8'h05, 8'h00, 6'd9);
    drive(o, '0);
    run_cycle();
    idle(); #1;
    check("t1_iss_valid", 32'(iss_valid), 32'd1);
    check("t1_base", 32'(iss_base), 32'h1234);
    check("t1_offset", 32'(iss_offset), 32'h05);
    iss_ready = 1'b1;
    run_cycle();
    iss_ready = 1'b0; #1;
    check("t1_head_advanced", 32'(iss_valid), 32'd0);

    // Table: back-to-back dispatch with the memory pipe always ready.
    sb_en = 1'b1; rob_head = 5'd10; iss_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].op, tbl[i].exp);
      run_cycle();
    end
    idle();
    drain("tbl_drain");
    sb_en = 1'b0; iss_ready = 1'b0;

    // CDB wakeup of base_lo at cycle N issues at N+1.
    o = mk_op(4'h0, 5'd7, 8'h21, 8'h00, 8'h03, 8'h00, 6'd1);
    o.blo_rdy = 1'b0; o.blo_tag = 6'd7;
    drive(o, '0);
    run_cycle();
    idle(); #1;
    check("t2_wait", 32'(iss_valid), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 8'hF0; #1;
    check("t2_wake_cycle", 32'(iss_valid), 32'd0);
    run_cycle();
    cdb_valid = 1'b0; #1;
    check("t2_iss_valid", 32'(iss_valid), 32'd1);
    check("t2_base", 32'(iss_base), 32'h21F0);
    iss_ready = 1'b1;
    run_cycle();
    iss_ready = 1'b0; #1;
    check("t2_done", 32'(iss_valid), 32'd0);

    // Store waits for ROB head.
    rob_head = 5'd1;
    drive(mk_op(4'h1, 5'd3, 8'h30, 8'h40, 8'h00, 8'h99, 6'd0), '0);
    run_cycle();
    idle(); #1;
    check("t3_blocked", 32'(iss_valid), 32'd0);
    rob_head = 5'd3; #1;
    check("t3_at_head", 32'(iss_valid), 32'd1);
    check("t3_data", 32'(iss_data), 32'h99);
    iss_ready = 1'b1;
    run_cycle();
    iss_ready = 1'b0; #1;
    check("t3_issued", 32'(iss_valid), 32'd0);

    // Fill to full, refuse while the head issues, then wrap and drain in order.
    sb_en = 1'b1; rob_head = 5'd0;
    for (int i = 0; i < 8; i++) begin
      drive(mk_op(4'h0, 5'(i + 8), 8'h40, 8'(i), 8'(2 * i), 8'h00, 6'(i + 20)),
            '{4'h0, 5'(i + 8), {8'h40, 8'(i)}, 8'(2 * i), 8'h00, 6'(i + 20)});
      run_cycle();
    end
    idle(); #1;
    check("t4_full", 32'(disp_ready), 32'd0);
    drive(mk_op(4'h0, 5'd16, 8'h41, 8'h08, 8'h10, 8'h00, 6'd28),
          '{4'h0, 5'd16, 16'h4108, 8'h10, 8'h00, 6'd28});
    iss_ready = 1'b1; #1;
    check("t4_full_while_issue", 32'(disp_ready), 32'd0);
    run_cycle();
    #1 check("t4_ready_after_issue", 32'(disp_ready), 32'd1);
    run_cycle();
    idle();
    drain("t4_drain");
    sb_en = 1'b0; iss_ready = 1'b0;

    // Flush beats a same-cycle dispatch.
    for (int i = 0; i < 5; i++) begin
      drive(mk_op(4'h0, 5'(i), 8'h50, 8'(i), 8'h00, 8'h00, 6'd2), '0);
      run_cycle();
    end
    drive(mk_op(4'h0, 5'd9, 8'h5F, 8'h00, 8'h00, 8'h00, 6'd2), '0);
    flush = 1'b1; iss_ready = 1'b1;
    run_cycle();
    idle(); iss_ready = 1'b0; #1;
    check("t5_iss_valid", 32'(iss_valid), 32'd0);
    check("t5_disp_ready", 32'(disp_ready), 32'd1);
    run_cycle();
    check("t5_still_empty", 32'(iss_valid), 32'd0);
    drive(mk_op(4'h0, 5'd1, 8'hBE, 8'hEF, 8'h00, 8'h00, 6'd2), '0);
    run_cycle();
    idle(); #1;
    check("t5_after_flush", 32'(iss_base), 32'hBEEF);
    iss_ready = 1'b1;
    run_cycle();
    iss_ready = 1'b0;

    // Dispatch an operand waiting on tag 9 while tag 9 is on the CDB.
    o = mk_op(4'h0, 5'd2, 8'h66, 8'h00, 8'h01, 8'h00, 6'd4);
    o.blo_rdy = 1'b0; o.blo_tag = 6'd9;
    drive(o, '0);
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 8'h5A; #1;
`ifdef MEM_IQ_CDB_BYPASS_EN
    check("t6_bypass_accept", 32'(disp_ready), 32'd1);
    run_cycle();
`else
    check("t6_stall", 32'(disp_ready), 32'd0);
    run_cycle();
    cdb_valid = 1'b0;
    o.blo_rdy = 1'b1; o.blo_val = 8'h5A;
    drive(o, '0); #1;
    check("t6_retry_accept", 32'(disp_ready), 32'd1);
    run_cycle();
`endif
    idle(); #1;
    check("t6_iss_valid", 32'(iss_valid), 32'd1);
    check("t6_base", 32'(iss_base), 32'h665A);
    iss_ready = 1'b1;
    run_cycle();
    iss_ready = 1'b0; #1;
    check("t6_done", 32'(iss_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
